// File: rtl/system_rst_seq.sv
// Clock/reset sequencer: holds the PLL in reset, qualifies its lock, then
// releases the downstream domain resets one after another with fixed spacing.
module system_rst_seq #(
  parameter int N_RST          = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 100000,
  parameter int DEBOUNCE       = 1024,
  parameter int STAGE_DELAY    = 256,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             soft_rst,
  output logic             pll_rst,
  output logic [N_RST-1:0] rst_out,
  output logic             ready,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  localparam int W_PLL = cw(PLL_RST_CYCLES);
  localparam int W_TO  = cw(LOCK_TIMEOUT);
  localparam int W_DB  = cw(DEBOUNCE);
  localparam int W_SD  = cw(STAGE_DELAY);
  localparam int W_A   = (W_PLL > W_TO) ? W_PLL : W_TO;
  localparam int W_B   = (W_DB > W_SD) ? W_DB : W_SD;
  localparam int W_CNT = (W_A > W_B) ? W_A : W_B;

  localparam logic [W_CNT-1:0] C_PLL_LAST = W_CNT'(PLL_RST_CYCLES - 1);
  localparam logic [W_CNT-1:0] C_TO_LAST  = W_CNT'(LOCK_TIMEOUT - 1);
  localparam logic [W_CNT-1:0] C_DB_LAST  = W_CNT'(DEBOUNCE - 1);
  localparam logic [W_CNT-1:0] C_SD_LAST  = W_CNT'(STAGE_DELAY - 1);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAIT     = 3'd1,
    S_DEBOUNCE = 3'd2,
    S_RELEASE  = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic [W_CNT-1:0]   r_cnt;
  logic [N_RST-1:0]   r_rst_out;
  logic               r_ready;
  logic               r_pll_rst;
  logic [CNT_W-1:0]   r_retry;
  logic [CNT_W-1:0]   r_loss;

  state_t             w_state_nxt;
  logic [W_CNT-1:0]   w_cnt_nxt;
  logic [N_RST-1:0]   w_rst_out_nxt;
  logic               w_ready_nxt;
  logic [CNT_W-1:0]   w_retry_nxt;
  logic [CNT_W-1:0]   w_loss_nxt;
  logic               w_lock_s;
  logic [N_RST-1:0]   w_rst_shift;
  logic [CNT_W-1:0]   w_retry_inc;
  logic [CNT_W-1:0]   w_loss_inc;

  assign w_lock_s    = r_sync[1];
  // Channels release by shifting zeros in from bit 0, so they can only clear in order.
  assign w_rst_shift = r_rst_out << 1;
  assign w_retry_inc = (&r_retry) ? r_retry : r_retry + 1'b1;
  assign w_loss_inc  = (&r_loss) ? r_loss : r_loss + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rst_out_nxt = r_rst_out;
    w_ready_nxt   = r_ready;
    w_retry_nxt   = r_retry;
    w_loss_nxt    = r_loss;
    if (soft_rst) begin
      w_state_nxt   = S_PLLRST;
      w_cnt_nxt     = '0;
      w_rst_out_nxt = '1;
      w_ready_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_PLLRST: begin
          if (r_cnt == C_PLL_LAST) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (w_lock_s) begin
            w_state_nxt = S_DEBOUNCE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == C_TO_LAST) begin
            w_state_nxt = S_PLLRST;
            w_cnt_nxt   = '0;
            w_retry_nxt = w_retry_inc;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (!w_lock_s) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
            w_loss_nxt  = w_loss_inc;
          end else if (r_cnt == C_DB_LAST) begin
            w_state_nxt   = S_RELEASE;
            w_cnt_nxt     = '0;
            w_rst_out_nxt = w_rst_shift;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (!w_lock_s) begin
            w_state_nxt   = S_WAIT;
            w_cnt_nxt     = '0;
            w_rst_out_nxt = '1;
            w_ready_nxt   = 1'b0;
            w_loss_nxt    = w_loss_inc;
          end else if (r_state == S_RELEASE) begin
            // An all-released vector here only happens with a single channel.
            if (r_rst_out == '0) begin
              w_state_nxt = S_RUN;
              w_ready_nxt = 1'b1;
            end else if (r_cnt == C_SD_LAST) begin
              w_cnt_nxt     = '0;
              w_rst_out_nxt = w_rst_shift;
              if (w_rst_shift == '0) begin
                w_state_nxt = S_RUN;
                w_ready_nxt = 1'b1;
              end
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_state_nxt   = S_PLLRST;
          w_cnt_nxt     = '0;
          w_rst_out_nxt = '1;
          w_ready_nxt   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_PLLRST;
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_pll_rst <= 1'b1;
      r_retry   <= '0;
      r_loss    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sync    <= {r_sync[0], pll_locked};
      r_cnt     <= w_cnt_nxt;
      r_rst_out <= w_rst_out_nxt;
      r_ready   <= w_ready_nxt;
      r_pll_rst <= (w_state_nxt == S_PLLRST);
      r_retry   <= w_retry_nxt;
      r_loss    <= w_loss_nxt;
    end
  end

  assign pll_rst   = r_pll_rst;
  assign rst_out   = r_rst_out;
  assign ready     = r_ready;
  assign state     = r_state;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_system_rst_seq.sv
// Directed bench for system_rst_seq: clean start, no lock with saturating
// retries, debounce glitch, lock loss in RUN, soft reset and reset mid-RUN.
module tb_system_rst_seq;

  localparam int N_RST = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             pll_locked;
  logic             soft_rst;
  logic             pll_rst;
  logic [N_RST-1:0] rst_out;
  logic             ready;
  logic [2:0]       state;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  system_rst_seq #(
    .N_RST(N_RST), .PLL_RST_CYCLES(4), .LOCK_TIMEOUT(20),
    .DEBOUNCE(8), .STAGE_DELAY(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst(soft_rst),
    .pll_rst(pll_rst), .rst_out(rst_out), .ready(ready), .state(state),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_pll_rst"}, pll_rst, 1);
    chk({tag, "_rst_out"}, rst_out, 7);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
    chk({tag, "_loss"}, loss_cnt, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    soft_rst = 1'b0;
    repeat (3) tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    soft_rst = 1'b0;
    pll_locked = 1'b0;

    // Clean start: DEBOUNCE entered at edge 5, releases at 13/18/23
    pll_locked = 1'b1;
    apply_reset();
    for (int i = 1; i <= 30; i++)
      exp_q.push_back((i < 13) ? 7 : (i < 18) ? 6 : (i < 23) ? 4 : 0);
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("clean_state", state,
          (i < 4) ? 0 : (i == 4) ? 1 : (i < 13) ? 2 : (i < 23) ? 3 : 4);
      chk("clean_pll_rst", pll_rst, (i < 4) ? 1 : 0);
      chk("clean_rst_out", rst_out, exp_q.pop_front());
      chk("clean_ready", ready, (i >= 23) ? 1 : 0);
    end
    chk("clean_retry", retry_cnt, 0);
    chk("clean_loss", loss_cnt, 0);

    // No lock: 24-cycle retry period, retry_cnt saturates at 3
    pll_locked = 1'b0;
    apply_reset();
    for (int i = 1; i <= 124; i++) begin
      tick();
      chk("nolock_pll_rst", pll_rst, ((i % 24) < 4) ? 1 : 0);
      chk("nolock_state", state, ((i % 24) < 4) ? 0 : 1);
      chk("nolock_retry", retry_cnt, ((i / 24) > 3) ? 3 : (i / 24));
      chk("nolock_rst_out", rst_out, 7);
    end

    // Debounce glitch: high 5, low 3, then high
    pll_locked = 1'b0;
    apply_reset();
    run_to(6);  pll_locked = 1'b1;
    run_to(11); pll_locked = 1'b0;
    run_to(13);
    chk("glitch_deb_state", state, 2);
    chk("glitch_deb_loss", loss_cnt, 0);
    run_to(14); pll_locked = 1'b1;
    chk("glitch_wait_state", state, 1);
    chk("glitch_loss", loss_cnt, 1);
    run_to(16); chk("glitch_wait2_state", state, 1);
    run_to(17); chk("glitch_deb2_state", state, 2);
    run_to(24); chk("glitch_pre_rel", rst_out, 7);
    run_to(25);
    chk("glitch_rel_rst_out", rst_out, 6);
    chk("glitch_rel_state", state, 3);
    chk("glitch_loss_end", loss_cnt, 1);

    // Lock loss in RUN, relock, then rst mid-RUN
    pll_locked = 1'b1;
    apply_reset();
    run_to(25);
    chk("loss_run_state", state, 4);
    chk("loss_run_ready", ready, 1);
    pll_locked = 1'b0;
    run_to(27);
    chk("loss_e2_rst_out", rst_out, 0);
    chk("loss_e2_ready", ready, 1);
    run_to(28);
    chk("loss_e3_rst_out", rst_out, 7);
    chk("loss_e3_ready", ready, 0);
    chk("loss_e3_state", state, 1);
    chk("loss_e3_cnt", loss_cnt, 1);
    pll_locked = 1'b1;
    run_to(31); chk("relock_deb_state", state, 2);
    run_to(38); chk("relock_38", rst_out, 7);
    run_to(39); chk("relock_39", rst_out, 6); chk("relock_39_state", state, 3);
    run_to(43); chk("relock_43", rst_out, 6);
    run_to(44); chk("relock_44", rst_out, 4);
    run_to(48); chk("relock_48", rst_out, 4); chk("relock_48_ready", ready, 0);
    run_to(49);
    chk("relock_49", rst_out, 0);
    chk("relock_49_ready", ready, 1);
    chk("relock_49_state", state, 4);
    rst = 1'b1;
    tick();
    chk_reset_vals("rst_mid_run");
    rst = 1'b0;

    // soft_rst mid-RELEASE, then soft_rst coinciding with lock-loss detection
    pll_locked = 1'b1;
    apply_reset();
    run_to(15);
    chk("soft_pre_rst_out", rst_out, 6);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_rst_out", rst_out, 7);
    chk("soft_state", state, 0);
    chk("soft_pll_rst", pll_rst, 1);
    chk("soft_ready", ready, 0);
    run_to(19); chk("soft_pll_rst_19", pll_rst, 1);
    run_to(20); chk("soft_pll_rst_20", pll_rst, 0); chk("soft_state_20", state, 1);
    run_to(21); chk("soft_state_21", state, 2);
    run_to(28); chk("soft_rel_28", rst_out, 7);
    run_to(29); chk("soft_rel_29", rst_out, 6);
    chk("soft_retry", retry_cnt, 0);
    chk("soft_loss", loss_cnt, 0);
    pll_locked = 1'b0;
    run_to(31);
    soft_rst = 1'b1;
    tick();
    soft_rst = 1'b0;
    chk("soft_vs_loss_state", state, 0);
    chk("soft_vs_loss_cnt", loss_cnt, 0);
    chk("soft_vs_loss_rst_out", rst_out, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/system_rst_seq.md
# system_rst_seq

Parametrised clock/reset sequencer: the successor to the plain PLL wrapper. Runs on the free-running board clock and drives the PLL reset. It qualifies the PLL `locked` signal (synchronise, debounce, timeout with retry), then releases N downstream domain resets in a fixed order with programmable spacing. On lock loss it re-asserts every domain reset. It sits between the board clock/PLL and all camera, DDR and video datapath blocks.

## Interface
Parameters:
- `N_RST`, 2: number of sequenced domain reset outputs (1..8).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per PLL reset attempt (≥1).
- `LOCK_TIMEOUT`, 100000: cycles allowed in WAIT for lock before retrying (≥2).
- `DEBOUNCE`, 1024: consecutive synced-lock cycles required before release (≥1).
- `STAGE_DELAY`, 256: cycles between successive channel releases (≥1).
- `CNT_W`, 8: width of the status counters.

Ports:
- `clk`, in, 1: free-running input clock (not a PLL output).
- `rst`, in, 1: synchronous, active-high reset.
- `pll_locked`, in, 1: PLL lock, asynchronous to `clk`.
- `soft_rst`, in, 1: single-cycle request to restart the full sequence.
- `pll_rst`, out, 1: active-high PLL reset.
- `rst_out`, out, N_RST: active-high domain resets; bit 0 is released first.
- `ready`, out, 1: all domains released, in RUN.
- `state`, out, 3: current FSM state code.
- `retry_cnt`, out, CNT_W: lock-timeout retries, saturating.
- `loss_cnt`, out, CNT_W: lock losses after debounce started, saturating.

## Operation
- `pll_locked` passes through a 2-flop synchroniser (reset to 0) to form `lock_s`. All FSM decisions use `lock_s`.
- FSM states (`state` code):
  - PLLRST (0): `pll_rst`=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT.
  - WAIT (1): if `lock_s`=1, go to DEBOUNCE. If the wait counter reaches LOCK_TIMEOUT-1 with no lock, increment `retry_cnt` and go to PLLRST.
  - DEBOUNCE (2): if `lock_s` stays 1 for DEBOUNCE consecutive cycles, go to RELEASE. If `lock_s`=0, go to WAIT; the wait counter restarts from 0 and `loss_cnt` increments.
  - RELEASE (3): `rst_out[k]` deasserts k×STAGE_DELAY cycles after `rst_out[0]` deasserts. `rst_out[0]` deasserts in the first RELEASE cycle.
  - RUN (4): all `rst_out`=0. Entered in the same cycle `rst_out[N_RST-1]` deasserts; `ready`=1 while in RUN.
- Lock loss: `lock_s`=0 in RELEASE or RUN sets all `rst_out`=1 and `ready`=0 on the next edge, moves to WAIT, and increments `loss_cnt`.
- `soft_rst`=1 in any state sets all `rst_out`=1 and `ready`=0 on the next edge and moves to PLLRST with its counter restarted. In PLLRST it restarts the count.
- Priority: `rst` > `soft_rst` > lock loss > timeout/normal progression.
- Once a channel is released it is never re-asserted individually. Any re-assertion covers all channels in the same cycle.
- `retry_cnt` and `loss_cnt` saturate at 2^CNT_W-1 and are cleared only by `rst`, not by `soft_rst`.
- `N_RST`=1: RELEASE lasts one cycle and RUN is entered immediately.
- Counter width for each parameter is $clog2 of its value; no counter wraps.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- During and after `rst`: state=PLLRST, `pll_rst`=1, `rst_out`=all 1, `ready`=0, both counters 0, synchroniser 0, all internal counters 0.
- `pll_rst` stays high for exactly PLL_RST_CYCLES cycles after `rst` falls, or after a `soft_rst` / timeout entry into PLLRST.
- Synchroniser latency is 2 cycles (`pll_locked` → `lock_s`). Each state transition adds 1 cycle after its condition is sampled.
- Reaction to lock loss: `rst_out` rises 3 edges after `pll_locked` falls (2 for sync, 1 for the register).
- Release latency from entering DEBOUNCE to `rst_out[0]`=0 is DEBOUNCE cycles.
- A `soft_rst` on the same edge as a timeout or lock loss: `soft_rst` wins and `retry_cnt`/`loss_cnt` do not increment.
- A lock glitch shorter than 2 cycles may be filtered by the synchroniser. This is acceptable.

## Test plan
Parameters for all scenarios: N_RST=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, DEBOUNCE=8, STAGE_DELAY=5.
- **Clean start:** `pll_locked`=1 throughout, `rst` released → `pll_rst` high exactly 4 cycles. `rst_out[0]` falls 8 cycles after DEBOUNCE entry, `rst_out[1]` 5 cycles later, `rst_out[2]` and `ready` 10 cycles after `rst_out[0]`. Counters stay 0.
- **No lock:** `pll_locked`=0 for 60 cycles → `pll_rst` pulses of 4 cycles repeat each 24 cycles. `retry_cnt` increments per timeout. `rst_out` stays all 1.
- **Debounce glitch:** lock high 5 cycles, low 3, then high → state returns to WAIT and `loss_cnt`=1. Release occurs 8 cycles after the second DEBOUNCE entry.
- **Loss in RUN:** in RUN, drop `pll_locked` → all `rst_out`=1 and `ready`=0 on the 3rd edge, state=WAIT, `loss_cnt`+1. Relock repeats the full release order.
- **`soft_rst` mid-RELEASE:** after `rst_out[0]` has fallen, pulse `soft_rst` → next edge has all `rst_out`=1, state=PLLRST, `pll_rst` high 4 cycles. Counters are unchanged.
- **Saturation:** CNT_W=2 with 5 forced timeouts → `retry_cnt` holds at 3. Asserting `rst` mid-RUN returns every output to its reset value on the next edge.
